// File: rtl/uart_ctl.sv
// Full-duplex UART: runtime baud divisor, optional parity, 1/2 stop bits,
// show-ahead TX/RX FIFOs and sticky line-error flags.

module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;
  logic [AW:0]   level_nxt;

  // full/empty are registered, so they gate this cycle's strobes
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign rdata = mem[rptr];

  always_comb begin
    level_nxt = level;
    if (do_wr && !do_rd)
      level_nxt = level + LVL_ONE;
    else if (do_rd && !do_wr)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end
endmodule

module uart_ctl #(
  parameter int DW      = 8,
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               cfg_par_en,
  input  logic               cfg_par_odd,
  input  logic               cfg_stop2,
  input  logic [DW-1:0]      tx_data,
  input  logic               tx_wr,
  output logic               tx_full,
  output logic [FIFO_AW:0]   tx_level,
  output logic               tx_busy,
  output logic               ser_txd,
  input  logic               ser_rxd,
  input  logic               rx_rd,
  output logic [DW-1:0]      rx_data,
  output logic               rx_empty,
  output logic [FIFO_AW:0]   rx_level,
  output logic               err_frame,
  output logic               err_parity,
  output logic               err_overrun,
  input  logic               err_clr,
  output logic [2:0]         tx_fsm,
  output logic [2:0]         rx_fsm
);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } st_t;

  // ---------------- TX ----------------
  st_t              tx_st;
  logic [DIV_W-1:0] tx_cnt;
  logic [DIV_W-1:0] tx_div;
  logic [DW-1:0]    tx_sh;
  logic [BW-1:0]    tx_bit;
  logic             tx_par;
  logic             tx_pe;
  logic             tx_s2;
  logic             tx_last;
  logic             tx_tick;
  logic             tx_pop;
  logic             tx_empty;
  logic [DW-1:0]    tx_head;

  uart_fifo #(.W(DW), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  assign tx_tick = (tx_cnt == tx_div);
  // Pop when idle, or at the very end of the last stop bit for gapless frames
  assign tx_pop  = ~tx_empty &
                   ((tx_st == S_IDLE) || ((tx_st == S_STOP) && tx_tick && tx_last));
  assign tx_busy = (tx_st != S_IDLE) | ~tx_empty;
  assign tx_fsm  = tx_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= S_IDLE;
      ser_txd <= 1'b1;
      tx_cnt  <= '0;
      tx_div  <= '0;
      tx_sh   <= '0;
      tx_bit  <= '0;
      tx_par  <= 1'b0;
      tx_pe   <= 1'b0;
      tx_s2   <= 1'b0;
      tx_last <= 1'b0;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + DIV_W'(1);
      case (tx_st)
        S_IDLE: begin
          tx_cnt  <= '0;
          ser_txd <= 1'b1;
        end
        S_START: begin
          if (tx_tick) begin
            ser_txd <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_bit  <= '0;
            tx_st   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            if (tx_bit == LAST_BIT) begin
              tx_last <= ~tx_s2;
              if (tx_pe) begin
                ser_txd <= tx_par;
                tx_st   <= S_PARITY;
              end else begin
                ser_txd <= 1'b1;
                tx_st   <= S_STOP;
              end
            end else begin
              ser_txd <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
              tx_bit  <= tx_bit + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (tx_tick) begin
            ser_txd <= 1'b1;
            tx_st   <= S_STOP;
          end
        end
        S_STOP: begin
          if (tx_tick) begin
            if (!tx_last) begin
              tx_last <= 1'b1;
            end else begin
              ser_txd <= 1'b1;
              tx_st   <= S_IDLE;
            end
          end
        end
        default: begin
          ser_txd <= 1'b1;
          tx_st   <= S_IDLE;
        end
      endcase
      // Frame config is captured with the byte so mid-frame cfg changes wait
      if (tx_pop) begin
        tx_sh   <= tx_head;
        tx_par  <= (^tx_head) ^ cfg_par_odd;
        tx_pe   <= cfg_par_en;
        tx_s2   <= cfg_stop2;
        tx_div  <= cfg_div;
        tx_cnt  <= '0;
        ser_txd <= 1'b0;
        tx_st   <= S_START;
      end
    end
  end

  // ---------------- RX ----------------
  st_t              rx_st;
  logic             rx_s1;
  logic             rxs;
  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W-1:0] rx_div;
  logic [DIV_W-1:0] rx_half;
  logic [DW-1:0]    rx_sh;
  logic [BW-1:0]    rx_bit;
  logic             rx_pe;
  logic             rx_odd;
  logic             rx_pbit;
  logic             rx_tick;
  logic             rx_push;
  logic             rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= ser_rxd;
      rxs   <= rx_s1;
    end
  end

  assign rx_tick = (rx_cnt == rx_div);
  assign rx_half = rx_div >> 1;
  assign rx_push = (rx_st == S_STOP) && rx_tick;
  assign rx_fsm  = rx_st;

  uart_fifo #(.W(DW), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (rx_push),
    .wdata (rx_sh),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_div  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
      rx_pe   <= 1'b0;
      rx_odd  <= 1'b0;
      rx_pbit <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + DIV_W'(1);
      case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rxs) begin
            // The edge cycle is count 0, so the start sample lands on half
            rx_cnt <= DIV_W'(1);
            rx_div <= cfg_div;
            rx_pe  <= cfg_par_en;
            rx_odd <= cfg_par_odd;
            rx_st  <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == rx_half) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rxs ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[DW-1:1]};
            rx_bit <= rx_bit + BW'(1);
            if (rx_bit == LAST_BIT)
              rx_st <= rx_pe ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (rx_tick) begin
            rx_cnt  <= '0;
            rx_pbit <= rxs;
            rx_st   <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // A new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= (err_frame & ~err_clr) | (rx_push & ~rxs);
      err_parity  <= (err_parity & ~err_clr) |
                     (rx_push & rx_pe & (rx_pbit != ((^rx_sh) ^ rx_odd)));
      err_overrun <= (err_overrun & ~err_clr) | (rx_push & rx_full);
    end
  end
endmodule

// File: tb/tb_uart_ctl.sv
// Directed bench for uart_ctl: per-bit TX waveform checks, loopback RX,
// injected line errors, FIFO bounds and mid-frame reset.

module tb_uart_ctl;
  localparam int DW      = 8;
  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [DIV_W-1:0]   cfg_div;
  logic               cfg_par_en;
  logic               cfg_par_odd;
  logic               cfg_stop2;
  logic [DW-1:0]      tx_data;
  logic               tx_wr;
  logic               tx_full;
  logic [FIFO_AW:0]   tx_level;
  logic               tx_busy;
  logic               ser_txd;
  logic               ser_rxd;
  logic               rx_rd;
  logic [DW-1:0]      rx_data;
  logic               rx_empty;
  logic [FIFO_AW:0]   rx_level;
  logic               err_frame;
  logic               err_parity;
  logic               err_overrun;
  logic               err_clr;
  logic [2:0]         tx_fsm;
  logic [2:0]         rx_fsm;

  logic               loop;
  logic               rxd_drv;

  // Handshake: tx_wr/rx_rd are single-cycle strobes sampled on posedge; a
  // strobe is accepted only when tx_full / rx_empty was low in that cycle.
  assign ser_rxd = loop ? ser_txd : rxd_drv;

  uart_ctl #(.DW(DW), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_div     (cfg_div),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_full     (tx_full),
    .tx_level    (tx_level),
    .tx_busy     (tx_busy),
    .ser_txd     (ser_txd),
    .ser_rxd     (ser_rxd),
    .rx_rd       (rx_rd),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_level    (rx_level),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_overrun (err_overrun),
    .err_clr     (err_clr),
    .tx_fsm      (tx_fsm),
    .rx_fsm      (rx_fsm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [15:0] div;
    logic        pe;
    logic        odd;
    logic        s2;
    logic        pbit;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic drive_rx(input logic v, input int n);
    rxd_drv = v;
    repeat (n) @(negedge clk);
  endtask

  // Bad stop is held low only 10 cycles so the re-armed receiver sees a glitch
  task automatic send_rx(input logic [7:0] d, input logic pe, input logic pbit, input logic stop_ok);
    int t;
    t = int'(cfg_div) + 1;
    drive_rx(1'b0, t);
    for (int k = 0; k < 8; k++) drive_rx(d[k], t);
    if (pe) drive_rx(pbit, t);
    if (stop_ok) drive_rx(1'b1, t + 32);
    else begin
      drive_rx(1'b0, 10);
      drive_rx(1'b1, 40);
    end
  endtask

  // Called on the first cycle of the start bit; returns on the cycle after the frame
  task automatic expect_tx_frame(input logic [7:0] d, input logic pe, input logic pbit,
                                 input logic s2, input string name);
    logic bits [12];
    int   nb;
    int   t;
    int   bad;
    t  = int'(cfg_div) + 1;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int k = 0; k < 8; k++) bits[nb++] = d[k];
    if (pe) bits[nb++] = pbit;
    bits[nb++] = 1'b1;
    if (s2) bits[nb++] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < t; c++) begin
        if (ser_txd !== bits[b]) bad++;
        if (b == nb - 1 && c == t - 1) check({name, "_busy_last"}, tx_busy, 1);
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_badcycles", name, b), bad, 0);
    end
  endtask

  task automatic wait_tx_idle(input int budget, input string name);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'hA5, 16'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 16'd15, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 16'd15, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 16'd15, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 16'd15, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h81, 16'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 16'd3,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 16'd15, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; cfg_div = 16'd15; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    tx_data = '0; tx_wr = 1'b0; rx_rd = 1'b0; err_clr = 1'b0; loop = 1'b0; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_txd", ser_txd, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_level", rx_level, 0);
    check("rst_errs", {err_frame, err_parity, err_overrun}, 0);
    check("rst_fsms", {tx_fsm, rx_fsm}, 0);

    // Table-driven single frames in loopback
    loop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cfg_div = vecs[i].div; cfg_par_en = vecs[i].pe;
      cfg_par_odd = vecs[i].odd; cfg_stop2 = vecs[i].s2;
      tx_data = vecs[i].d; tx_wr = 1'b1;
      @(negedge clk);
      tx_wr = 1'b0;
      check($sformatf("v%0d_txd_before_start", i), ser_txd, 1);
      @(negedge clk);
      expect_tx_frame(vecs[i].d, vecs[i].pe, vecs[i].pbit, vecs[i].s2, $sformatf("v%0d", i));
      check($sformatf("v%0d_busy_end", i), tx_busy, 0);
      check($sformatf("v%0d_txd_end", i), ser_txd, 1);
      check($sformatf("v%0d_rx_level", i), rx_level, 1);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].d);
      check($sformatf("v%0d_errs", i), {err_frame, err_parity, err_overrun}, 0);
      pop_rx();
      check($sformatf("v%0d_rx_empty", i), rx_empty, 1);
    end

    // 8E2 back-to-back, three writes on consecutive cycles
    cfg_div = 16'd15; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
    tx_data = 8'h07; tx_wr = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    @(negedge clk);
    tx_data = 8'hFF;
    fork
      begin
        @(negedge clk);
        tx_wr = 1'b0;
      end
    join_none
    expect_tx_frame(8'h07, 1'b1, 1'b1, 1'b1, "b2b0");
    expect_tx_frame(8'h00, 1'b1, 1'b0, 1'b1, "b2b1");
    expect_tx_frame(8'hFF, 1'b1, 1'b0, 1'b1, "b2b2");
    check("b2b_busy_end", tx_busy, 0);
    check("b2b_txd_end", ser_txd, 1);
    exp_q.push_back(8'h07); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    check("b2b_rx_level3", rx_level, 3);
    while (exp_q.size() > 0) begin
      check("b2b_rx_data", rx_data, exp_q.pop_front());
      pop_rx();
      check("b2b_rx_level", rx_level, exp_q.size());
    end
    check("b2b_errs", {err_frame, err_parity, err_overrun}, 0);

    // Injected RX errors
    loop = 1'b0;
    cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    check("ferr_flag", err_frame, 1);
    check("ferr_others", {err_parity, err_overrun}, 0);
    check("ferr_level", rx_level, 1);
    check("ferr_data", rx_data, 8'h5A);
    pop_rx();
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
    send_rx(8'h07, 1'b1, 1'b0, 1'b1);
    check("perr_flag", err_parity, 1);
    check("perr_frame_sticky", err_frame, 1);
    check("perr_data", rx_data, 8'h07);
    pop_rx();
    check("perr_empty", rx_empty, 1);
    pulse_clr();
    check("clr_errs", {err_frame, err_parity, err_overrun}, 0);
    send_rx(8'hC3, 1'b1, 1'b0, 1'b0);
    check("ferr2_flags", {err_frame, err_parity, err_overrun}, 3'b100);
    check("ferr2_level", rx_level, 1);

    // Reset in the middle of a TX frame with a byte queued and RX non-empty
    cfg_par_en = 1'b0;
    tx_data = 8'hF0; tx_wr = 1'b1;
    @(negedge clk);
    tx_data = 8'h0F;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (30) @(negedge clk);
    check("prerst_busy", tx_busy, 1);
    check("prerst_level", tx_level, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_txd", ser_txd, 1);
    @(negedge clk);
    check("postrst_txd", ser_txd, 1);
    check("postrst_tx_level", tx_level, 0);
    check("postrst_tx_busy", tx_busy, 0);
    check("postrst_rx_empty", rx_empty, 1);
    check("postrst_errs", {err_frame, err_parity, err_overrun}, 0);
    repeat (20) @(negedge clk);
    check("postrst_txd_idle", ser_txd, 1);

    // 4-cycle low pulse must be rejected
    drive_rx(1'b0, 4);
    drive_rx(1'b1, 40);
    check("glitch_empty", rx_empty, 1);
    check("glitch_level", rx_level, 0);
    check("glitch_errs", {err_frame, err_parity, err_overrun}, 0);

    // TX FIFO bound: 18 writes, 17 frames
    cfg_div = 16'd15; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          if (i == 17) begin
            check("txf_full", tx_full, 1);
            check("txf_level16", tx_level, 16);
          end
          tx_data = 8'(8'h40 + i);
          tx_wr = 1'b1;
          @(negedge clk);
        end
        tx_wr = 1'b0;
        check("txf_level_after_drop", tx_level, 16);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++)
          expect_tx_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0, $sformatf("txf%0d", i));
        check("txf_busy_end", tx_busy, 0);
        check("txf_txd_end", ser_txd, 1);
        check("txf_level_end", tx_level, 0);
      end
    join

    // RX overrun: 17 looped frames, nothing read
    loop = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(8'h20 + i);
      tx_wr = 1'b1;
      if (i < 16) exp_q.push_back(8'(8'h20 + i));
      @(negedge clk);
    end
    tx_wr = 1'b0;
    wait_tx_idle(4000, "ovr_tx_idle");
    repeat (30) @(negedge clk);
    check("ovr_level", rx_level, 16);
    check("ovr_flag", err_overrun, 1);
    check("ovr_others", {err_frame, err_parity}, 0);
    while (exp_q.size() > 0) begin
      check("ovr_data", rx_data, exp_q.pop_front());
      pop_rx();
    end
    check("ovr_empty", rx_empty, 1);
    pulse_clr();
    check("ovr_clr", {err_frame, err_parity, err_overrun}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
